// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, A - B, LSB first.
// Captures operands from SW on START in IDLE, then takes one bit step per
// clock through a single borrow flop. LEDR/LEDG[0] update only at completion.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   RST      - synchronous active-high reset
//   START    - start request, honoured only in IDLE
//   SW       - {B, A} operands, WIDTH bits each
//   LEDR     - difference (A - B) mod 2^WIDTH of last completed operation
//   LEDG     - [0] final borrow (A < B), [1] one-cycle done strobe
//   BUSY     - high while bit steps are in progress
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RST,
  input  logic                 START,
  input  logic [2*WIDTH-1:0]   SW,
  output logic [WIDTH-1:0]     LEDR,
  output logic [1:0]           LEDG,
  output logic                 BUSY
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, a_sr_n;
  logic [WIDTH-1:0] b_sr, b_sr_n;
  logic [WIDTH-1:0] res_sr, res_sr_n;
  logic             br, br_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] ledr_n;
  logic [1:0]       ledg_n;
  logic             busy_n;
  logic             d;
  logic             br_step;

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      LEDR   <= '0;
      LEDG   <= 2'b00;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_n;
      a_sr   <= a_sr_n;
      b_sr   <= b_sr_n;
      res_sr <= res_sr_n;
      br     <= br_n;
      cnt    <= cnt_n;
      LEDR   <= ledr_n;
      LEDG   <= ledg_n;
      BUSY   <= busy_n;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_n  = state;
    a_sr_n   = a_sr;
    b_sr_n   = b_sr;
    res_sr_n = res_sr;
    br_n     = br;
    cnt_n    = cnt;
    ledr_n   = LEDR;
    ledg_n   = {1'b0, LEDG[0]};   // done strobe self-clears
    busy_n   = BUSY;
    d        = a_sr[0] ^ b_sr[0] ^ br;
    br_step  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    case (state)
      IDLE: begin
        if (START) begin
          a_sr_n  = SW[WIDTH-1:0];
          b_sr_n  = SW[2*WIDTH-1:WIDTH];
          br_n    = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_n   = {1'b0, a_sr[WIDTH-1:1]};
        b_sr_n   = {1'b0, b_sr[WIDTH-1:1]};
        res_sr_n = {d, res_sr[WIDTH-1:1]};
        br_n     = br_step;
        cnt_n    = cnt + CW'(1);
        // Last step: publish the result including this step's bit
        if (cnt == CW'(WIDTH - 1)) begin
          ledr_n  = {d, res_sr[WIDTH-1:1]};
          ledg_n  = {1'b1, br_step};
          busy_n  = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): table-driven
// subtraction vectors plus directed sequences for ignored START/SW,
// mid-operation reset and continuously held START.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*W-1:0] sw;
  logic [W-1:0]   ledr;
  logic [1:0]     ledg;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .START    (start),
    .SW       (sw),
    .LEDR     (ledr),
    .LEDG     (ledg),
    .BUSY     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation observed from the capture edge through 11 more edges.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_br,
                        input logic [7:0] prev_d, input bit scramble,
                        input string nm);
    int busy_cnt;
    int strobes;
    int first_strobe;
    bit overlap;
    @(negedge clk);
    sw = {b, a};
    start = 1'b1;
    @(negedge clk);       // capture edge 0 has passed
    start = 1'b0;
    busy_cnt = 0;
    strobes = 0;
    first_strobe = -1;
    overlap = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (ledg[1]) begin
        strobes++;
        if (first_strobe < 0) first_strobe = k;
      end
      if (busy && ledg[1]) overlap = 1'b1;
      if (k == 4) check({nm, " ledr_hold"}, int'(ledr), int'(prev_d));
      if (scramble) begin
        if (k >= 2 && k <= 6) begin
          sw = 16'($urandom);
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    check({nm, " busy_cycles"}, busy_cnt, 8);
    check({nm, " strobes"}, strobes, 1);
    check({nm, " strobe_edge"}, first_strobe, 8);
    check({nm, " busy_done_overlap"}, int'(overlap), 0);
    check({nm, " ledr"}, int'(ledr), int'(exp_d));
    check({nm, " borrow"}, int'(ledg[0]), int'(exp_br));
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] prev;
    int strobes;
    int busy_seen;
    int last_k;
    int gap_bad;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, br: 1'b0};
    vecs[1] = '{a: 8'h3C, b: 8'h5A, d: 8'hE2, br: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, br: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, br: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h00, d: 8'h80, br: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h80, d: 8'h81, br: 1'b1};

    rst = 1'b1;
    start = 1'b1;         // reset must win over START
    sw = 16'h3C5A;
    repeat (3) @(negedge clk);
    check("reset ledr", int'(ledr), 0);
    check("reset ledg", int'(ledg), 0);
    check("reset busy", int'(busy), 0);
    start = 1'b0;
    rst = 1'b0;

    // Table-driven subtraction vectors
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, prev, 1'b0,
             $sformatf("vec%0d", i));
      prev = vecs[i].d;
    end

    // START and SW activity while busy must be ignored
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, prev, 1'b1, "ignore");
    prev = 8'h1E;

    // Reset during bit step 4 discards the operation
    @(negedge clk);
    sw = {8'h01, 8'h10};
    start = 1'b1;
    @(negedge clk);       // after capture edge 0
    start = 1'b0;
    repeat (4) @(negedge clk);   // after edge 4
    rst = 1'b1;
    @(negedge clk);       // edge 5 (bit step 4) applied reset
    check("midreset ledr", int'(ledr), 0);
    check("midreset ledg", int'(ledg), 0);
    check("midreset busy", int'(busy), 0);
    rst = 1'b0;
    strobes = 0;
    busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ledg[1]) strobes++;
      if (busy) busy_seen++;
    end
    check("midreset no_strobe", strobes, 0);
    check("midreset stays_idle", busy_seen, 0);
    check("midreset ledr_after", int'(ledr), 0);

    // START held high: a new operation every WIDTH+2 edges
    @(negedge clk);
    sw = {8'h03, 8'h05};
    start = 1'b1;
    strobes = 0;
    last_k = -1;
    gap_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);     // sample after edge k, edge 0 = first capture
      if (ledg[1]) begin
        strobes++;
        check($sformatf("held ledr k%0d", k), int'(ledr), 8'h02);
        check($sformatf("held borrow k%0d", k), int'(ledg[0]), 0);
        if (last_k < 0) begin
          if (k != 8) gap_bad++;
        end else if (k - last_k != 10) begin
          gap_bad++;
        end
        last_k = k;
      end
    end
    start = 1'b0;
    check("held strobe_count", strobes, 4);
    check("held strobe_spacing", gap_bad, 0);
    repeat (12) @(negedge clk);
    check("held drained busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor for the DE2 lab series, complementing the half adder with a sequential difference engine. It captures two WIDTH-bit operands from the switches on a start request and computes A − B one bit per clock, LSB first, through a single borrow flop. It presents the difference and final borrow on the LEDs with a one-cycle done strobe. It is a standalone top-level exercise module clocked from the board 50 MHz oscillator.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..16.
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- START  input  1  start request; level-sampled, honoured only in IDLE.
- SW  input  2*WIDTH  operands: SW[WIDTH-1:0] = A (minuend), SW[2*WIDTH-1:WIDTH] = B (subtrahend), unsigned.
- LEDR  output  WIDTH  registered difference (A − B) mod 2^WIDTH from the last completed operation.
- LEDG  output  2  LEDG[0] = final borrow of the last completed operation (1 iff A < B); LEDG[1] = done strobe.
- BUSY  output  1  high while an operation is in progress (state SHIFT).

## Operation
- States are IDLE, SHIFT and DONE; all outputs and internal registers are registered.
- Reset (RST=1 at an edge), from any state including mid-operation:
  - state goes to IDLE.
  - LEDR = 0, LEDG = 2'b00, BUSY = 0.
  - Operand shift registers, result shift register, borrow flop and bit counter all cleared.
  - RST has priority over START.
- IDLE:
  - If START=1 at an edge: load A and B from SW into the operand shift registers, clear borrow and counter, go to SHIFT, set BUSY=1.
  - Otherwise remain in IDLE.
- SHIFT, one bit step per edge. Let a = A_sr[0], b = B_sr[0], br = borrow flop.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - d shifts into the MSB of the result shift register, which shifts right; A_sr and B_sr shift right.
  - counter increments.
  - On the step where counter == WIDTH-1, also:
    - load LEDR with the completed result, including this step's d.
    - load LEDG[0] with br_next.
    - set LEDG[1] = 1, BUSY = 0, and go to DONE.
- DONE: at the next edge, LEDG[1] = 0 and state goes to IDLE. LEDR and LEDG[0] hold.
- START is ignored in SHIFT and DONE; there is no queueing.
- SW changes after the capture edge have no effect on the running operation.
- START held high continuously starts a new operation on every IDLE visit, i.e. every WIDTH+2 edges.
- LEDR and LEDG[0] change only at completion (or reset). During SHIFT they show the previous result.
- Arithmetic is pure modulo 2^WIDTH with borrow-out. There is no signed interpretation and no overflow flag.

## Timing
- Edge 0: START sampled high in IDLE; BUSY=1 after this edge.
- Edges 1..WIDTH: bit steps 0..WIDTH-1.
- After edge WIDTH: LEDR and LEDG[0] valid, LEDG[1]=1, BUSY=0.
- After edge WIDTH+1: LEDG[1]=0, state is IDLE.
- Earliest next capture is at edge WIDTH+2.
- Latency from the START capture edge to valid result is WIDTH cycles. LEDG[1] is exactly one cycle wide.
- BUSY and LEDG[1] are never high in the same cycle. BUSY is high for exactly WIDTH cycles per operation.
- Reset asserted mid-SHIFT: the partial result is discarded, there is no done strobe, and the block is idle the cycle after reset.

## Test plan
- WIDTH=8, SW = {B=8'h3C, A=8'h5A}, START pulse 1 cycle -> BUSY high 8 cycles, then LEDR=8'h1E, LEDG[0]=0, LEDG[1] high exactly 1 cycle, 8 edges after capture.
- A=8'h3C, B=8'h5A -> LEDR=8'hE2, LEDG[0]=1. Then A=8'h00, B=8'h01 -> LEDR=8'hFF, LEDG[0]=1.
- A=8'hFF, B=8'hFF -> LEDR=8'h00, LEDG[0]=0. Then A=8'h80, B=8'h00 -> LEDR=8'h80, LEDG[0]=0.
- Start A=8'h5A, B=8'h3C. Toggle SW to random values and pulse START during cycles 2..7 -> result still 8'h1E with a single done strobe. The first new operation begins only after return to IDLE.
- Complete one operation, then start A=8'h10, B=8'h01 and assert RST at bit step 4 -> LEDR=0, LEDG=0, BUSY=0 the cycle after reset. No done strobe follows.
- START held high for 40 cycles with A=8'h05, B=8'h03 -> done strobes every 10 cycles, each with LEDR=8'h02, LEDG[0]=0.
